// File: rtl/user_reg_responder.sv
// Register-bus responder and interrupt handshake for user_logic_top.
// Optional event counter at 0x18 is built only when USER_REG_EVT_CNT_EN is defined.
module user_reg_responder #(
  parameter logic [31:0] ID_VALUE = 32'h5543_0001,
  parameter int          CNT_W    = 16
) (
  input  logic        i_user_clk,
  input  logic        i_rst,
  input  logic [19:0] i_user_addr,
  input  logic [31:0] i_user_data,
  input  logic        i_user_wr_req,
  input  logic        i_user_rd_req,
  output logic [31:0] o_user_data,
  output logic        o_user_rd_ack,
  output logic        o_intr_req,
  input  logic        i_intr_ack,
  output logic [31:0] o_ctrl,
  input  logic [31:0] i_status,
  input  logic        i_event
);

  localparam logic [2:0] REG_ID        = 3'd0;
  localparam logic [2:0] REG_CTRL      = 3'd1;
  localparam logic [2:0] REG_STATUS    = 3'd2;
  localparam logic [2:0] REG_INTR_EN   = 3'd3;
  localparam logic [2:0] REG_INTR_STAT = 3'd4;
  localparam logic [2:0] REG_SCRATCH   = 3'd5;
  localparam logic [2:0] REG_EVT_CNT   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } intr_state_t;

  intr_state_t state_r, state_nxt_s;
  logic [31:0] ctrl_r, scratch_r, rd_data_r, rd_data_s;
  logic        intr_en_r, pending_r, rd_ack_r, intr_req_r;
  logic        hit_s, wr_ctrl_s, wr_en_s, wr_stat_s, wr_scratch_s;
  logic [2:0]  sel_s;
  logic        unused_s;

  assign hit_s        = (i_user_addr[19:5] == 15'd0);
  assign sel_s        = i_user_addr[4:2];
  assign wr_ctrl_s    = i_user_wr_req && hit_s && (sel_s == REG_CTRL);
  assign wr_en_s      = i_user_wr_req && hit_s && (sel_s == REG_INTR_EN);
  assign wr_stat_s    = i_user_wr_req && hit_s && (sel_s == REG_INTR_STAT);
  assign wr_scratch_s = i_user_wr_req && hit_s && (sel_s == REG_SCRATCH);

`ifdef USER_REG_EVT_CNT_EN
  logic [CNT_W-1:0] evt_cnt_r;
  logic             wr_cnt_s;
  assign wr_cnt_s = i_user_wr_req && hit_s && (sel_s == REG_EVT_CNT);
  assign unused_s = ^i_user_addr[1:0];

  // Event counter: a write clears it, a coincident event makes it 1
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      evt_cnt_r <= {CNT_W{1'b0}};
    end else if (wr_cnt_s) begin
      evt_cnt_r <= i_event ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (i_event) begin
      evt_cnt_r <= evt_cnt_r + CNT_W'(1);
    end
  end
`else
  assign unused_s = ^{i_user_addr[1:0], 1'(CNT_W)};
`endif

  // Writable registers; event set dominates a same-cycle W1C of pending
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      ctrl_r    <= 32'd0;
      scratch_r <= 32'd0;
      intr_en_r <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      if (wr_ctrl_s)    ctrl_r    <= i_user_data;
      if (wr_scratch_s) scratch_r <= i_user_data;
      if (wr_en_s)      intr_en_r <= i_user_data[0];
      if (i_event)                         pending_r <= 1'b1;
      else if (wr_stat_s && i_user_data[0]) pending_r <= 1'b0;
    end
  end

  // Read mux sees pre-write register values
  always_comb begin
    rd_data_s = 32'd0;
    if (hit_s) begin
      case (sel_s)
        REG_ID:        rd_data_s = ID_VALUE;
        REG_CTRL:      rd_data_s = ctrl_r;
        REG_STATUS:    rd_data_s = i_status;
        REG_INTR_EN:   rd_data_s = {31'd0, intr_en_r};
        REG_INTR_STAT: rd_data_s = {31'd0, pending_r};
        REG_SCRATCH:   rd_data_s = scratch_r;
`ifdef USER_REG_EVT_CNT_EN
        REG_EVT_CNT:   rd_data_s = 32'(evt_cnt_r);
`endif
        default:       rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Read response pipeline, one cycle latency
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      rd_ack_r  <= 1'b0;
      rd_data_r <= 32'd0;
    end else begin
      rd_ack_r  <= i_user_rd_req;
      rd_data_r <= i_user_rd_req ? rd_data_s : 32'd0;
    end
  end

  // A reset arriving while an ack is in flight squashes it in that same cycle
  assign o_user_rd_ack = rd_ack_r & ~i_rst;
  assign o_user_data   = rd_data_r & {32{~i_rst}};
  assign o_ctrl        = ctrl_r;
  assign o_intr_req    = intr_req_r;

  // Interrupt FSM state and registered request
  always_ff @(posedge i_user_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      intr_req_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      intr_req_r <= (state_nxt_s == ST_REQ);
    end
  end

  // Interrupt FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_r && intr_en_r) state_nxt_s = ST_REQ;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (i_intr_ack)                   state_nxt_s = ST_WAIT_CLR;
        else if (!intr_en_r || !pending_r) state_nxt_s = ST_IDLE;
        else                              state_nxt_s = ST_REQ;
      end
      ST_WAIT_CLR: begin
        if (!pending_r) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_WAIT_CLR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_user_reg_responder.sv
// Scoreboard bench for user_reg_responder; honours USER_REG_EVT_CNT_EN (uses CNT_W=4 when defined).
module tb_user_reg_responder;

  localparam logic [31:0] ID_VAL = 32'h5543_0001;
`ifdef USER_REG_EVT_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic        user_clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] addr = 20'd0;
  logic [31:0] wdata = 32'd0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [31:0] rdata, ctrl;
  logic        rd_ack, intr_req;
  logic        intr_ack = 1'b0;
  logic [31:0] status = 32'd0;
  logic        evt = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic        prev_rd = 1'b0, prev_rst = 1'b1;

  user_reg_responder #(.ID_VALUE(ID_VAL), .CNT_W(CW)) dut (
    .i_user_clk(user_clk), .i_rst(rst), .i_user_addr(addr), .i_user_data(wdata),
    .i_user_wr_req(wr_req), .i_user_rd_req(rd_req), .o_user_data(rdata),
    .o_user_rd_ack(rd_ack), .o_intr_req(intr_req), .i_intr_ack(intr_ack),
    .o_ctrl(ctrl), .i_status(status), .i_event(evt)
  );

  always #5 user_clk = ~user_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_read(input logic [19:0] a, input logic [31:0] exp);
    addr = a; rd_req = 1'b1; exp_q.push_back(exp);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic pulse_event();
    evt = 1'b1;
    tick();
    evt = 1'b0;
  endtask

  // Strobe history for the ack-timing expectation
  always @(posedge user_clk) begin
    prev_rd  <= rd_req;
    prev_rst <= rst;
  end

  // Scoreboard: every ack pops one expected read value
  always @(negedge user_clk) begin
    logic exp_ack;
    exp_ack = prev_rd && !prev_rst && !rst;
    if (exp_ack || rd_ack) check_eq("rd_ack", {31'd0, rd_ack}, {31'd0, exp_ack});
    if (rd_ack) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else check_eq("rd_data", rdata, exp_q.pop_front());
    end else if (rdata !== 32'd0) begin
      check_eq("idle_data", rdata, 32'd0);
    end
  end

  initial begin
    repeat (3) tick();
    check_eq("rst_ack", {31'd0, rd_ack}, 32'd0);
    check_eq("rst_data", rdata, 32'd0);
    check_eq("rst_intr", {31'd0, intr_req}, 32'd0);
    check_eq("rst_ctrl", ctrl, 32'd0);
    rst = 1'b0;
    tick();

    // Basic decode
    do_read(20'h00000, ID_VAL);
    do_read(20'h00004, 32'd0);
    check_eq("ctrl_init", ctrl, 32'd0);
    do_write(20'h00014, 32'hA5A5_0F0F);
    do_read(20'h00014, 32'hA5A5_0F0F);
    do_read(20'h0001C, 32'd0);
    do_read(20'h00100, 32'd0);
    do_write(20'h00114, 32'hFFFF_FFFF);
    do_read(20'h00000, ID_VAL);
    do_read(20'h00014, 32'hA5A5_0F0F);
    do_read(20'h00004, 32'd0);
    do_write(20'h00004, 32'h1234_5678);
    check_eq("ctrl_out", ctrl, 32'h1234_5678);
    do_read(20'h00004, 32'h1234_5678);
    status = 32'hDEAD_BEEF;
    do_read(20'h00008, 32'hDEAD_BEEF);
    status = 32'h0000_0000;

    // Same-cycle write and read returns the old value
    addr = 20'h00014; wdata = 32'h0BAD_F00D; wr_req = 1'b1; rd_req = 1'b1;
    exp_q.push_back(32'hA5A5_0F0F);
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    do_read(20'h00014, 32'h0BAD_F00D);

    // Interrupt handshake
    do_write(20'h0000C, 32'hFFFF_FFFF);
    do_read(20'h0000C, 32'd1);
    pulse_event();
    check_eq("intr_n1", {31'd0, intr_req}, 32'd0);
    tick();
    check_eq("intr_n2", {31'd0, intr_req}, 32'd1);
    tick();
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    check_eq("intr_ack_drop", {31'd0, intr_req}, 32'd0);
    pulse_event();
    repeat (3) tick();
    check_eq("intr_wait_clr", {31'd0, intr_req}, 32'd0);
    do_write(20'h00010, 32'd1);
    do_read(20'h00010, 32'd0);
    tick();
    pulse_event();
    tick();
    check_eq("intr_reraise", {31'd0, intr_req}, 32'd1);
    do_write(20'h0000C, 32'd0);
    tick();
    check_eq("intr_disable", {31'd0, intr_req}, 32'd0);

    // W1C versus event, then masked pending
    addr = 20'h00010; wdata = 32'd1; wr_req = 1'b1; evt = 1'b1;
    tick();
    wr_req = 1'b0; evt = 1'b0;
    do_read(20'h00010, 32'd1);
    repeat (2) tick();
    check_eq("intr_masked", {31'd0, intr_req}, 32'd0);
    do_write(20'h0000C, 32'd1);
    tick();
    check_eq("intr_unmask", {31'd0, intr_req}, 32'd1);
    do_write(20'h00010, 32'd1);
    tick();
    check_eq("intr_w1c_idle", {31'd0, intr_req}, 32'd0);
    do_write(20'h0000C, 32'd0);

`ifdef USER_REG_EVT_CNT_EN
    do_write(20'h00018, 32'hFFFF_FFFF);
    do_read(20'h00018, 32'd0);
    for (int i = 0; i < 17; i++) pulse_event();
    do_read(20'h00018, 32'd1);
    addr = 20'h00018; wdata = 32'd0; wr_req = 1'b1; evt = 1'b1;
    tick();
    wr_req = 1'b0; evt = 1'b0;
    do_read(20'h00018, 32'd1);
`else
    pulse_event();
    do_read(20'h00018, 32'd0);
    do_write(20'h00018, 32'h0000_0005);
    do_read(20'h00018, 32'd0);
`endif
    do_write(20'h00010, 32'd1);

    // Reset during an in-flight read and an active request
    do_write(20'h0000C, 32'd1);
    pulse_event();
    tick();
    check_eq("intr_pre_rst", {31'd0, intr_req}, 32'd1);
    addr = 20'h00014; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; rst = 1'b1;
    #1;
    check_eq("rst_squash_ack", {31'd0, rd_ack}, 32'd0);
    tick();
    check_eq("rst_intr_drop", {31'd0, intr_req}, 32'd0);
    rst = 1'b0;
    tick();
    do_read(20'h00004, 32'd0);
    do_read(20'h00014, 32'd0);
    do_read(20'h0000C, 32'd0);
    do_read(20'h00010, 32'd0);
    check_eq("ctrl_post_rst", ctrl, 32'd0);
    repeat (3) tick();
    check_eq("sb_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/user_reg_responder.md
# user_reg_responder

User-side responder for the PCIe register interface and the interrupt handshake. It decodes register writes and reads issued by `pcie_top` over the `user_*` register bus and returns read data with a one-cycle acknowledge. It also drives the `user_intr_req`/`user_intr_ack` interrupt handshake from a software-maskable event source. It sits inside `user_logic_top` and is the terminating end of the register bus and interrupt line.

## Interface
Parameters:
- `ID_VALUE`, 32'h5543_0001, constant returned by the ID register.
- `CNT_W`, 16, event-counter width (1..32).

Ports:
- `i_user_clk`  in  1  sole clock; all logic on rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_user_addr`  in  20  byte address; only `[4:2]` decoded, `[19:5]` must be zero for a hit.
- `i_user_data`  in  32  write data.
- `i_user_wr_req`  in  1  one-cycle write strobe.
- `i_user_rd_req`  in  1  one-cycle read strobe.
- `o_user_data`  out  32  read data, valid only while `o_user_rd_ack`=1.
- `o_user_rd_ack`  out  1  one-cycle read acknowledge.
- `o_intr_req`  out  1  interrupt request level.
- `i_intr_ack`  in  1  interrupt acknowledge pulse from the PCIe core.
- `o_ctrl`  out  32  CTRL register contents to user logic.
- `i_status`  in  32  live status from user logic.
- `i_event`  in  1  event pulse, one per cycle max.

## Operation
- Register map (byte offset, hit requires `addr[19:5]`=0):
  - 0x00 ID: RO, `ID_VALUE`.
  - 0x04 CTRL: RW, reset 0, drives `o_ctrl`.
  - 0x08 STATUS: RO, `i_status` sampled on the read-strobe cycle.
  - 0x0C INTR_EN: RW, bit0 only; upper bits read 0.
  - 0x10 INTR_STAT: bit0 pending. Set by `i_event`. Write 1 to clear (W1C).
  - 0x14 SCRATCH: RW, reset 0.
  - 0x18 EVT_CNT: RO, zero-extended `CNT_W` counter of `i_event` pulses. Wraps at 2^CNT_W. Any write clears it.
  - 0x1C, and all misses: read 32'h0; writes ignored.
- Simultaneous `i_user_wr_req` and `i_user_rd_req` to the same register: read returns the pre-write value.
- `i_event` and a W1C on INTR_STAT in the same cycle: the set wins and pending stays 1.
- `i_event` and a write to EVT_CNT in the same cycle: the counter becomes 1.
- Interrupt FSM:
  - IDLE -> REQ when pending=1 and INTR_EN=1. `o_intr_req` is 1 in REQ only.
  - REQ -> WAIT_CLR on `i_intr_ack`.
  - REQ -> IDLE if INTR_EN is written to 0 or pending is cleared before the ack; no ack is then expected.
  - WAIT_CLR -> IDLE once pending=0. A new event during WAIT_CLR does not re-raise until pending is cleared and set again.
  - `i_intr_ack` in IDLE or WAIT_CLR is ignored.

## Timing
- Reset values: `o_user_data`=0, `o_user_rd_ack`=0, `o_intr_req`=0, `o_ctrl`=0. FSM=IDLE, INTR_EN=0, pending=0, SCRATCH=0, counter=0.
- Read latency is fixed at 1: a strobe at cycle N gives `o_user_rd_ack`=1 with data at N+1.
- Back-to-back strobes on consecutive cycles each get an ack on consecutive cycles.
- `o_user_data` returns to 0 in cycles without an ack.
- A write at cycle N is visible in the register and on `o_ctrl` at N+1. A read strobed at N+1 returns the new value.
- Event at N: pending and the counter update at N+1. `o_intr_req` rises at N+2 if enabled.
- `i_intr_ack` at N: `o_intr_req` falls at N+1.
- `i_rst` asserted mid-transaction:
  - A pending read ack is squashed; no ack is issued for a strobe captured in the reset cycle.
  - The FSM returns to IDLE and `o_intr_req` drops the next cycle.

## Configuration
- Macro `USER_REG_EVT_CNT_EN`.
- Defined: EVT_CNT is implemented as above.
- Undefined:
  - No counter logic.
  - 0x18 reads 32'h0 and writes to it are ignored.
  - Interrupt behaviour is unchanged.

## Test plan
- Reset, then read 0x00 -> ack one cycle after the strobe, data 32'h5543_0001. Read 0x04 -> 0, and `o_ctrl`=0.
- Write 0x14=32'hA5A5_0F0F, then read 0x14 on the next cycle -> 32'hA5A5_0F0F. Read 0x1C and read addr 20'h00100 -> 0. Three back-to-back reads -> three consecutive acks.
- Write INTR_EN=1, pulse `i_event` at N -> `o_intr_req`=1 at N+2. Ack at M -> `o_intr_req`=0 at M+1. A second event while WAIT_CLR -> no request. W1C 0x10 -> IDLE. The next event re-raises.
- W1C on INTR_STAT coincident with `i_event` -> INTR_STAT reads 1. With INTR_EN=0, an event sets pending but `o_intr_req` stays 0. Setting INTR_EN=1 afterwards -> request raised.
- With `USER_REG_EVT_CNT_EN` and `CNT_W`=4: 17 events -> EVT_CNT reads 1. Write 0x18 coincident with an event -> reads 1. Without the macro -> 0x18 reads 0.
- Assert `i_rst` the cycle after a read strobe and while `o_intr_req`=1 -> no ack, `o_intr_req`=0, CTRL/SCRATCH read 0 after reset.
